// File: rtl/axis_cmd_ram.sv
// Single-port RAM driven by an AXI-Stream command slave (write/read beats) with an
// AXI-Stream read-response master and an optional post-reset zeroing sweep.
module axis_cmd_ram #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned DEPTH          = 288,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDR_W+DATA_W:0]   s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {StClear, StIdle, StRd, StLoad, StResp} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    clr_q, clr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                s_tready_q, s_tready_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic                m_tuser_q, m_tuser_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   ram_q;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [IDX_W-1:0]    rd_idx;

  logic                cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                cmd_fire;
  logic                cmd_in_range;
  logic                rd_in_range;

  assign cmd_op       = s_axis_tdata[ADDR_W+DATA_W];
  assign cmd_addr     = s_axis_tdata[ADDR_W+DATA_W-1:DATA_W];
  assign cmd_wdata    = s_axis_tdata[DATA_W-1:0];
  assign cmd_fire     = s_axis_tvalid && s_tready_q && (state_q == StIdle);
  // Full-width compare: out-of-range addresses never alias onto real words.
  assign cmd_in_range = 32'(cmd_addr) < DEPTH;
  assign rd_in_range  = 32'(addr_q) < DEPTH;
  assign rd_idx       = rd_in_range ? addr_q[IDX_W-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    addr_d     = addr_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    mem_we     = 1'b0;
    mem_widx   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      StClear: begin
        mem_we   = 1'b1;
        mem_widx = clr_q;
        if (clr_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          clr_d = clr_q + IDX_W'(1);
        end
      end
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_op) begin
            mem_we    = cmd_in_range;
            mem_widx  = cmd_addr[IDX_W-1:0];
            mem_wdata = cmd_wdata;
          end else begin
            addr_d  = cmd_addr;
            state_d = StRd;
          end
        end
      end
      // Array read lands in ram_q; the output stage registers it one cycle later.
      StRd: state_d = StLoad;
      StLoad: begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = rd_in_range ? ram_q : '0;
        m_tuser_d  = !rd_in_range;
        state_d    = StResp;
      end
      StResp: begin
        if (m_axis_tready) begin
          m_tvalid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    s_tready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);

    if (!aresetn) begin
      state_d    = CLEAR_ON_RESET ? StClear : StIdle;
      clr_d      = '0;
      addr_d     = '0;
      s_tready_d = 1'b0;
      m_tvalid_d = 1'b0;
      m_tdata_d  = '0;
      m_tuser_d  = 1'b0;
      busy_d     = 1'b1;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    state_q    <= state_d;
    clr_q      <= clr_d;
    addr_q     <= addr_d;
    s_tready_q <= s_tready_d;
    m_tvalid_q <= m_tvalid_d;
    m_tdata_q  <= m_tdata_d;
    m_tuser_q  <= m_tuser_d;
    busy_q     <= busy_d;
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
    ram_q <= mem[rd_idx];
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
  assign busy          = busy_q;

endmodule
